// File: rtl/dff_pipe_if.sv
// Handshake bundle for dff_pipe: producer side (in_*), consumer side (out_*) and occupancy count.
// The pipeline uses the slave modport; the environment driving it uses the master modport.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage elastic register pipeline with per-stage valid bits and bubble collapse.
// Defining DFF_PIPE_FLUSH_EN adds a synchronous flush port that clears all valid bits.
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic      clk,
  input  logic      reset,
`ifdef DFF_PIPE_FLUSH_EN
  input  logic      flush,
`endif
  dff_pipe_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [CW-1:0]    cnt;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [DEPTH-1:0] v_next;

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] vec);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + CW'(vec[i]);
    end
    return n;
  endfunction

  // Ready ripples back from the consumer; an empty stage is always ready.
  always_comb begin
    logic chain;
    chain = bus.out_ready;
    rdy   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = ~v[i] | chain;
      rdy[i] = chain;
    end
  end

  // Upstream view of each stage and the resulting next valid vector.
  always_comb begin
    up_v[0] = bus.in_valid;
    up_d[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i]) begin
        v_next[i] = up_v[i];
      end else begin
        v_next[i] = v[i];
      end
    end
  end

  // Stage registers and occupancy count; data only moves when a valid item arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      v   <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VAL;
      end
    end
`ifdef DFF_PIPE_FLUSH_EN
    else if (flush) begin
      v   <= '0;
      cnt <= '0;
    end
`endif
    else begin
      v   <= v_next;
      cnt <= popcount(v_next);
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i] && up_v[i]) begin
          d[i] <= up_d[i];
        end
      end
    end
  end

`ifdef DFF_PIPE_FLUSH_EN
  assign bus.in_ready  = rdy[0] & ~flush;
`else
  assign bus.in_ready  = rdy[0];
`endif
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];
  assign bus.count     = cnt;
endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: directed scenarios plus random traffic against a slot model
// and an in-order scoreboard of accepted items.
module tb_dff_pipe;
  localparam int               WIDTH = 8;
  localparam int               DEPTH = 4;
  localparam logic [WIDTH-1:0] RV    = 8'h00;

  logic clk   = 1'b0;
  logic reset = 1'b1;
`ifdef DFF_PIPE_FLUSH_EN
  logic flush = 1'b0;
`endif

  dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef DFF_PIPE_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int               n_tests = 0;
  int               n_fail  = 0;
  int               n_out   = 0;
  bit               last_acc;
  bit               mv [DEPTH];
  logic [WIDTH-1:0] md [DEPTH];
  logic [WIDTH-1:0] sb [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int occupancy();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(mv[i]);
    return n;
  endfunction

  // One clock: check ready before the edge, advance the slot model, check outputs after it.
  task automatic cycle();
    bit               can_take [DEPTH+1];
    bit               nv [DEPTH];
    logic [WIDTH-1:0] nd [DEPTH];
    bit               uv;
    logic [WIDTH-1:0] ud;
    bit               fl;
    bit               exp_rdy;
    #2;
    fl = 1'b0;
`ifdef DFF_PIPE_FLUSH_EN
    fl = flush;
`endif
    // A slot can take a new occupant if it is empty or its occupant is leaving.
    can_take[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) can_take[i] = !mv[i] || can_take[i+1];
    exp_rdy = can_take[0] && !fl;
    check_val("in_ready", bus.in_ready, exp_rdy);
    last_acc = bus.in_valid && exp_rdy;
    for (int i = 0; i < DEPTH; i++) begin
      uv = (i == 0) ? bus.in_valid : mv[i-1];
      ud = (i == 0) ? bus.in_data  : md[i-1];
      nv[i] = can_take[i] ? uv : mv[i];
      nd[i] = (can_take[i] && uv) ? ud : md[i];
    end
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin nv[i] = 1'b0; nd[i] = RV; end
      sb.delete();
      last_acc = 1'b0;
    end else if (fl) begin
      for (int i = 0; i < DEPTH; i++) begin nv[i] = 1'b0; nd[i] = md[i]; end
      sb.delete();
      last_acc = 1'b0;
    end else begin
      if (mv[DEPTH-1] && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) check_val("sb_nonempty", 32'd0, 32'd1);
        else check_val("order", bus.out_data, sb.pop_front());
      end
      if (last_acc) sb.push_back(bus.in_data);
    end
    @(posedge clk);
    #1;
    mv = nv;
    md = nd;
    check_val("out_valid", bus.out_valid, mv[DEPTH-1]);
    check_val("out_data", bus.out_data, md[DEPTH-1]);
    check_val("count", bus.count, occupancy());
  endtask

  task automatic fill(input int n, input logic [WIDTH-1:0] base);
    int got;
    got = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4 * DEPTH && got < n; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + WIDTH'(got);
      cycle();
      if (last_acc) got++;
    end
    bus.in_valid = 1'b0;
    check_val("fill_accepted", got, n);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    for (int c = 0; c < DEPTH + 2; c++) cycle();
    check_val("drained", bus.count, 0);
  endtask

  task automatic latency(input logic [WIDTH-1:0] val);
    int n;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = val;
    cycle();
    check_val("lat_accept", last_acc, 1);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 3 * DEPTH) begin
      cycle();
      n++;
    end
    check_val("latency", n, DEPTH);
    check_val("lat_data", bus.out_data, val);
    cycle();
    check_val("lat_gone", bus.out_valid, 0);
  endtask

  initial begin
    int k;
    int outs0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) begin mv[i] = 1'b0; md[i] = RV; end
    reset = 1'b0;
    #1;
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_data", bus.out_data, RV);
    check_val("rst_count", bus.count, 0);
    check_val("rst_in_ready", bus.in_ready, 1);

    latency(8'hA5);

    // Backpressure fill: items 1..5, only 4 fit.
    bus.out_ready = 1'b0;
    k = 1;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(k);
      cycle();
      if (last_acc) k++;
    end
    check_val("full_count", bus.count, DEPTH);
    check_val("full_accepted", k, 5);
    check_val("full_in_ready", bus.in_ready, 0);
    outs0 = n_out;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12 && (k <= 5 || sb.size() != 0); c++) begin
      bus.in_valid = (k <= 5);
      bus.in_data  = WIDTH'(k);
      cycle();
      if (last_acc) k++;
    end
    check_val("fill_outputs", n_out - outs0, 5);
    drain();

    // Bubble collapse with alternating input valid.
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < DEPTH; c++) begin
      bus.in_valid = (c % 2 == 0);
      bus.in_data  = 8'h10 + WIDTH'(k);
      cycle();
      if (last_acc) k++;
    end
    bus.in_valid = 1'b0;
    check_val("bubble_count", bus.count, DEPTH);
    drain();

    // Full-pipe streaming.
    fill(DEPTH, 8'h40);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h80 + WIDTH'(c);
      #1;
      check_val("stream_rdy", bus.in_ready, 1);
      cycle();
      check_val("stream_count", bus.count, DEPTH);
    end
    drain();

    // Reset mid-stream.
    fill(3, 8'h20);
    check_val("pre_rst_count", bus.count, 3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_val("mid_rst_valid", bus.out_valid, 0);
    check_val("mid_rst_count", bus.count, 0);
    check_val("mid_rst_data", bus.out_data, RV);
    latency(8'h3C);

`ifdef DFF_PIPE_FLUSH_EN
    fill(2, 8'h60);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    flush = 1'b1;
    #1;
    check_val("flush_in_ready", bus.in_ready, 0);
    cycle();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check_val("flush_count", bus.count, 0);
    drain();
`endif

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = WIDTH'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      reset         = ($urandom_range(0, 299) == 0);
`ifdef DFF_PIPE_FLUSH_EN
      flush         = ($urandom_range(0, 149) == 0);
`endif
      cycle();
    end
    reset = 1'b0;
`ifdef DFF_PIPE_FLUSH_EN
    flush = 1'b0;
`endif
    drain();
    check_val("sb_empty_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
